// File: rtl/fpu_pkg.sv
// Shared FPU types and default widths for the effective-subtraction mantissa path.
// Combinational only: no latency, no flow control.
package fpu_pkg;
  localparam int MW_DEF = 24;
  localparam int EW_DEF = 8;
  localparam int LZW    = $clog2(MW_DEF + 1);

  typedef struct packed {
    logic [MW_DEF-1:0] d;
    logic              bout;
    logic [EW_DEF-1:0] exp;
  } sub_s1_t;

  typedef struct packed {
    logic [MW_DEF-1:0] mant;
    logic [EW_DEF-1:0] exp;
    logic              swap;
    logic              zero;
    logic              uflow;
  } sub_res_t;
endpackage

// File: rtl/borrow_lookahead_6bit.sv
// 6-bit borrow-lookahead generator: per-bit borrows plus group propagate/generate.
// Combinational, zero latency; no flow control.
module borrow_lookahead_6bit (
  input  logic       bin,
  input  logic [5:0] p,
  input  logic [5:0] g,
  output logic       b1,
  output logic       b2,
  output logic       b3,
  output logic       b4,
  output logic       b5,
  output logic       bout,
  output logic       grp_p,
  output logic       grp_g
);
  logic [6:1] gt;
  logic [6:1] pt;
  logic [6:1] b;
  logic       term;
  logic       acc;

  // Each borrow is a flat sum of products over lower bits, never a ripple of earlier borrows.
  always_comb begin
    gt   = '0;
    pt   = '0;
    term = 1'b0;
    acc  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      term = 1'b0;
      acc  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        term = term | (acc & g[j]);
        acc  = acc & p[j];
      end
      gt[i+1] = term;
      pt[i+1] = acc;
    end
  end

  assign b = gt | (pt & {6{bin}});
  assign {bout, b5, b4, b3, b2, b1} = b;
  assign grp_g = gt[6];
  assign grp_p = pt[6];
endmodule

// File: rtl/mant_sub_norm.sv
// Two-stage |A-B| significand subtract then LZC normalize with exponent adjust; latency 2.
// Valid/ready both sides; in_ready drops only when both stages are full and out_ready is low.
module mant_sub_norm
  import fpu_pkg::*;
#(
  parameter int MW = MW_DEF,
  parameter int EW = EW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] a_mant,
  input  logic [MW-1:0] b_mant,
  input  logic [EW-1:0] a_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] res_mant,
  output logic [EW-1:0] res_exp,
  output logic          res_swap,
  output logic          res_zero,
  output logic          res_uflow
);
  localparam int NG = MW / 6;

  function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
    lzc = LZW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (v[i]) lzc = LZW'(MW - 1 - i);
    end
  endfunction

  // ---------------- stage 1: borrow-lookahead subtract ----------------
  logic [MW-1:0] p, g, bin_vec;
  logic [NG-1:0] grp_p, grp_g, grp_bo;
  logic [NG:0]   c;
  logic          c_term, c_acc;
  logic          unused_grp_bo;

  assign g = ~a_mant & b_mant;
  assign p = ~(a_mant ^ b_mant);

  for (genvar k = 0; k < NG; k++) begin : g_grp
    logic b1, b2, b3, b4, b5;
    borrow_lookahead_6bit u_bla (
      .bin   (c[k]),
      .p     (p[6*k +: 6]),
      .g     (g[6*k +: 6]),
      .b1    (b1),
      .b2    (b2),
      .b3    (b3),
      .b4    (b4),
      .b5    (b5),
      .bout  (grp_bo[k]),
      .grp_p (grp_p[k]),
      .grp_g (grp_g[k])
    );
    assign bin_vec[6*k +: 6] = {b5, b4, b3, b2, b1, c[k]};
  end

  // Group borrows come from a second lookahead level; the unit's borrow-in is 0.
  always_comb begin
    c      = '0;
    c_term = 1'b0;
    c_acc  = 1'b1;
    for (int k = 0; k < NG; k++) begin
      c_term = 1'b0;
      c_acc  = 1'b1;
      for (int j = k; j >= 0; j--) begin
        c_term = c_term | (c_acc & grp_g[j]);
        c_acc  = c_acc & grp_p[j];
      end
      c[k+1] = c_term;
    end
  end

  assign unused_grp_bo = ^grp_bo;

  sub_s1_t s1_q, s1_d;
  logic    s1_vld_q, s1_vld_d;
  logic    s1_load, s2_load;
  logic    s2_vld_q, s2_vld_d;

  assign s2_load  = !s2_vld_q || out_ready;
  assign s1_load  = !s1_vld_q || s2_load;
  assign in_ready = s1_load;

  always_comb begin
    s1_d      = s1_q;
    s1_vld_d  = s1_vld_q;
    if (s1_load) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_d.d    = a_mant ^ b_mant ^ bin_vec;
        s1_d.bout = c[NG];
        s1_d.exp  = a_exp;
      end
    end
  end

  // ---------------- stage 2: magnitude, normalize, exponent adjust ----------------
  sub_res_t      res_q, res_d, res_n;
  logic [MW-1:0] mag;
  logic [LZW-1:0] lz;

  always_comb begin
    mag   = s1_q.bout ? (~s1_q.d + MW'(1)) : s1_q.d;
    lz    = lzc(mag);
    res_n = '0;
    if (mag == '0) begin
      res_n.zero = 1'b1;
    end else if ({{EW{1'b0}}, lz} > {{LZW{1'b0}}, s1_q.exp}) begin
      res_n.zero  = 1'b1;
      res_n.uflow = 1'b1;
      res_n.swap  = s1_q.bout;
    end else begin
      res_n.mant = mag << lz;
      res_n.exp  = s1_q.exp - EW'(lz);
      res_n.swap = s1_q.bout;
    end
  end

  always_comb begin
    res_d    = res_q;
    s2_vld_d = s2_vld_q;
    if (s2_load) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) res_d = res_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s1_q     <= '0;
      res_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s1_q     <= s1_d;
      res_q    <= res_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign res_mant  = res_q.mant;
  assign res_exp   = res_q.exp;
  assign res_swap  = res_q.swap;
  assign res_zero  = res_q.zero;
  assign res_uflow = res_q.uflow;
endmodule

// File: tb/tb_mant_sub_norm.sv
// Directed-vector bench for mant_sub_norm: reset, single results, stalled stream, mid-flight reset.
// Inputs change and outputs are sampled just after the falling edge.
module tb_mant_sub_norm;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] a_mant;
  logic [23:0] b_mant;
  logic [7:0]  a_exp;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] res_mant;
  logic [7:0]  res_exp;
  logic        res_swap;
  logic        res_zero;
  logic        res_uflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mant_sub_norm dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_mant    (a_mant),
    .b_mant    (b_mant),
    .a_exp     (a_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_mant  (res_mant),
    .res_exp   (res_exp),
    .res_swap  (res_swap),
    .res_zero  (res_zero),
    .res_uflow (res_uflow)
  );

  wire [34:0] got = {res_mant, res_exp, res_swap, res_zero, res_uflow};

  // expected = {mant, exp, swap, zero, uflow}
  localparam logic [23:0] VA [8] = '{24'h800000, 24'h400000, 24'hABCDEF, 24'h000002,
                                     24'h000000, 24'h000001, 24'h000001, 24'h000000};
  localparam logic [23:0] VB [8] = '{24'h000001, 24'hC00000, 24'hABCDEF, 24'h000001,
                                     24'h000001, 24'h000000, 24'h000000, 24'hFFFFFF};
  localparam logic [7:0]  VE [8] = '{8'h80, 8'h10, 8'h44, 8'h02, 8'h03, 8'h17, 8'h16, 8'h09};
  localparam logic [34:0] VX [8] = '{{24'hFFFFFE, 8'h7F, 3'b000}, {24'h800000, 8'h10, 3'b100},
                                     {24'h000000, 8'h00, 3'b010}, {24'h000000, 8'h00, 3'b011},
                                     {24'h000000, 8'h00, 3'b111}, {24'h800000, 8'h00, 3'b000},
                                     {24'h000000, 8'h00, 3'b011}, {24'hFFFFFF, 8'h09, 3'b100}};

  localparam logic [23:0] SA [8] = '{24'hC00000, 24'h100000, 24'h000010, 24'h000100,
                                     24'hFFFFFF, 24'h000000, 24'h000001, 24'h123456};
  localparam logic [23:0] SB [8] = '{24'h400000, 24'h200000, 24'h000010, 24'h000001,
                                     24'h000000, 24'h000003, 24'h000000, 24'h023456};
  localparam logic [7:0]  SE [8] = '{8'h20, 8'h30, 8'h05, 8'h40, 8'h01, 8'h50, 8'h10, 8'h7F};
  localparam logic [34:0] SX [8] = '{{24'h800000, 8'h20, 3'b000}, {24'h800000, 8'h2D, 3'b100},
                                     {24'h000000, 8'h00, 3'b010}, {24'hFF0000, 8'h30, 3'b000},
                                     {24'hFFFFFF, 8'h01, 3'b000}, {24'hC00000, 8'h3A, 3'b100},
                                     {24'h000000, 8'h00, 3'b011}, {24'h800000, 8'h7C, 3'b000}};

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_mant = '0; b_mant = '0; a_exp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++;
    if (got !== 35'h0) begin n_bad++; $display("FAIL reset_res got=%h want=0", got); end
  endtask

  task automatic test_vectors();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      a_mant = VA[i]; b_mant = VB[i]; a_exp = VE[i];
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL vec%0d_early_valid got=%b want=0", i, out_valid); end
      @(negedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL vec%0d_latency got=%b want=1", i, out_valid); end
      n_cmp++;
      if (got !== VX[i]) begin n_bad++; $display("FAIL vec%0d_result got=%h want=%h", i, got, VX[i]); end
    end
  endtask

  task automatic test_stream();
    int tx = 0, rx = 0, inflight = 0;
    logic stalled = 1'b0;
    logic [34:0] held = '0;
    logic acc, em;
    for (int cyc = 0; cyc < 200 && rx < 8; cyc++) begin
      @(negedge clk);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (tx < 8);
      if (tx < 8) begin a_mant = SA[tx]; b_mant = SB[tx]; a_exp = SE[tx]; end
      #1;
      n_cmp++;
      if (in_ready !== !(inflight == 2 && !out_ready)) begin
        n_bad++; $display("FAIL stream_in_ready cyc=%0d got=%b inflight=%0d out_ready=%b", cyc, in_ready, inflight, out_ready);
      end
      if (stalled) begin
        n_cmp++;
        if (out_valid !== 1'b1 || got !== held) begin
          n_bad++; $display("FAIL stream_hold cyc=%0d got=%b/%h want=1/%h", cyc, out_valid, got, held);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (rx >= 8) begin
          n_bad++; $display("FAIL stream_extra got=%h want=no result", got);
        end else if (got !== SX[rx]) begin
          n_bad++; $display("FAIL stream_res%0d got=%h want=%h", rx, got, SX[rx]);
        end
        rx++;
      end
      stalled = out_valid && !out_ready;
      held    = got;
      acc     = in_valid && in_ready;
      em      = out_valid && out_ready;
      if (acc) tx++;
      inflight = inflight + (acc ? 1 : 0) - (em ? 1 : 0);
    end
    n_cmp++;
    if (rx != 8) begin n_bad++; $display("FAIL stream_count got=%0d want=8", rx); end
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_dup got=%b/%h want=0", out_valid, got); end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    a_mant = 24'h800000; b_mant = 24'h000001; a_exp = 8'h80;
    @(negedge clk);
    a_mant = 24'h400000; b_mant = 24'hC00000; a_exp = 8'h10;
    @(negedge clk);
    a_mant = 24'hFFFFFF; b_mant = 24'h000000; a_exp = 8'h01;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b1 || got !== {24'hFFFFFE, 8'h7F, 3'b000}) begin
      n_bad++; $display("FAIL full_head got=%b/%h want=1/%h", out_valid, got, {24'hFFFFFE, 8'h7F, 3'b000});
    end
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    n_cmp++;
    if (got !== 35'h0) begin n_bad++; $display("FAIL midrst_res got=%h want=0", got); end
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_ghost got=%b/%h want=0", out_valid, got); end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stream();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mant_sub_norm.md
# mant_sub_norm

Two-stage pipelined mantissa subtract-and-normalize unit for the FPU's effective-subtraction path. Computes |A − B| of two 24-bit significands with borrow-lookahead logic (the subtraction counterpart of the adder's carry-lookahead generators). It then normalizes the magnitude with a leading-zero count and left shift, and adjusts the exponent. Sits between the alignment shifter and the rounding stage, with valid/ready handshakes on both sides.

## Interface
Parameters:
- MW, 24, significand width; must be a multiple of 6.
- EW, 8, exponent width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  unit can accept operands this cycle.
- a_mant  in  MW  minuend significand (aligned, hidden bit included).
- b_mant  in  MW  subtrahend significand (aligned).
- a_exp  in  EW  common exponent of the aligned operands.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- res_mant  out  MW  normalized magnitude; MSB is 1 unless res_zero.
- res_exp  out  EW  adjusted exponent.
- res_swap  out  1  B > A; the result sign must be inverted downstream.
- res_zero  out  1  exact zero or underflow flush.
- res_uflow  out  1  normalization shift exceeded a_exp.

## Operation
Stage 1 (subtract):
- Per bit: borrow-generate g = ~a & b; borrow-propagate p = ~(a ^ b).
- MW/6 groups of `borrow_lookahead_6bit`. Group borrow-in comes from a group-level lookahead, not a ripple through the groups. Borrow-in to bit 0 is 0.
- d[i] = a[i] ^ b[i] ^ bin[i].
- Registered outputs: d, bout (final borrow), and a_exp.

Stage 2 (normalize):
- mag = bout ? (~d + 1) : d, truncated to MW bits.
- lz = leading-zero count of mag, range 0..MW.
- If mag == 0: res_mant = 0, res_exp = 0, res_zero = 1, res_uflow = 0, res_swap = 0.
- Else if lz > a_exp: res_mant = 0, res_exp = 0, res_zero = 1, res_uflow = 1.
- Else: res_mant = mag << lz, res_exp = a_exp − lz, res_zero = 0, res_uflow = 0.
- res_swap = bout in all cases except the zero case.

Handshake:
- A transfer happens on a cycle where valid && ready are both high.
- Each stage holds its own valid bit.
- Stage 2 loads when it is empty or when out_ready is high.
- Stage 1 loads when it is empty or when stage 2 loads.
- in_ready equals the stage-1 load condition.
- Full throughput: 1 result per cycle when out_ready stays high.
- While out_valid is high and out_ready is low, all res_* outputs hold stable.

## Timing
- Latency: operands accepted at edge N appear with out_valid at edge N+2. There are no bubbles when output is not stalled.
- Reset: both valid bits clear. out_valid = 0; in_ready = 1 on the first cycle after reset. res_mant = 0, res_exp = 0, res_swap = 0, res_zero = 0, res_uflow = 0.
- Reset mid-operation: in-flight operands are discarded and never emitted.
- Simultaneous accept and emit in the same cycle is legal. In-flight data must not be duplicated or lost.
- Stall: with both stages full and out_ready low, in_ready = 0 in the same cycle. in_ready is combinational from out_ready.
- Back-to-back stalls release in order, oldest result first.

## Structure
- Shared package `fpu_pkg`:
  - MW and EW defaults.
  - A `sub_s1_t` struct holding d, bout, exp.
  - A `sub_res_t` struct holding mant, exp, swap, zero, uflow.
- Sub-module `borrow_lookahead_6bit`: inputs bin and p[5:0], g[5:0]; outputs b1..b5 and bout, plus group P and G for the group-level lookahead.
- The leading-zero counter is an in-module function, not a separate module.

## Test plan
- a=0x800000, b=0x000001, a_exp=0x80 → res_mant=0xFFFFFE, res_exp=0x7F, swap=0, zero=0.
- a=0x400000, b=0xC00000, a_exp=0x10 → mag 0x800000, res_mant=0x800000, res_exp=0x10, swap=1.
- a=b=0xABCDEF → res_zero=1, res_mant=0, res_exp=0, swap=0, uflow=0.
- a=0x000002, b=0x000001, a_exp=2 → lz=23 > 2, so res_zero=1, res_uflow=1.
- Stream 8 random pairs with out_ready toggling 1,0,0,1…:
  - results match a golden model, in order, with no drops or duplicates;
  - outputs are stable while stalled;
  - in_ready=0 only when both stages are full and out_ready=0.
- Assert rst for one cycle with both stages full → next cycle out_valid=0, in_ready=1, all res_* = 0; the discarded results never appear.
